sid_filter_ctrl: RTL and testbench

SID_FILTER_CTRL -- requirements
Module: sid_filter_ctrl

---
 rtl/sid_filter_ctrl.sv | 144 ++++++++++++++
 tb/tb_sid_filter_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_ctrl.sv
// SID filter sequencer: shadows the filter registers, looks up the cutoff, loads and fires
// the filter engine once per sample tick, and captures the previous result.
// Optional saturating overrun counter: define SID_FILTER_OVERRUN_CNT_EN.
module sid_filter_ctrl #(
    parameter int ENG_CYCLES = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_1m,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [7:0]  din,
    output logic [10:0] f0_addr,
    input  logic [17:0] f0_data,
    output logic [17:0] eng_f0,
    output logic [7:0]  eng_res_filt,
    output logic [7:0]  eng_mode_vol,
    output logic        eng_valid,
    input  logic [17:0] eng_sound,
    output logic [17:0] sound_out,
    output logic        sound_valid,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  overrun_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        LOAD   = 3'd2,
        FIRE   = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam int CW = $clog2(ENG_CYCLES + 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(ENG_CYCLES - 2);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] run_cnt;
    logic [2:0]    fc_lo;
    logic [7:0]    fc_hi;
    logic [7:0]    res_filt;
    logic [7:0]    mode_vol;
    logic          first_run;
    logic          valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ce_1m) state_next = LOOKUP;
            LOOKUP:  state_next = LOAD;
            LOAD:    state_next = FIRE;
            FIRE:    state_next = RUN;
            RUN:     if (run_cnt == RUN_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow writes are accepted in every state; a write landing in LOAD only reaches
    // the engine at the next sample because LOAD samples the pre-edge shadow values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_lo    <= '0;
            fc_hi    <= '0;
            res_filt <= '0;
            mode_vol <= '0;
        end else if (we) begin
            case (addr)
                5'h15:   fc_lo    <= din[2:0];
                5'h16:   fc_hi    <= din;
                5'h17:   res_filt <= din;
                5'h18:   mode_vol <= din;
                default: ;
            endcase
        end
    end

    assign f0_addr = {fc_hi, fc_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_f0       <= '0;
            eng_res_filt <= '0;
            eng_mode_vol <= '0;
            run_cnt      <= '0;
        end else begin
            if (state == LOAD) begin
                eng_f0       <= f0_data;
                eng_res_filt <= res_filt;
                eng_mode_vol <= mode_vol;
            end
            if (state == FIRE) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

    // First RUN cycle holds the result of the previous sample; after reset it is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            sound_out <= '0;
            valid_q   <= 1'b0;
            first_run <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            if (state == RUN && run_cnt == '0) begin
                sound_out <= eng_sound;
                valid_q   <= ~first_run;
                first_run <= 1'b0;
            end
        end
    end

    assign eng_valid   = (state == FIRE);
    assign busy        = (state != IDLE);
    assign overrun     = ce_1m & busy & ~rst;
    assign sound_valid = valid_q & ~rst;
    assign dbg_state   = state;

`ifdef SID_FILTER_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_cnt <= '0;
        end else if (overrun && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_sid_filter_ctrl.sv
// Directed bench for sid_filter_ctrl: stimulus pushes expected engine loads, captured
// samples and overrun counts into queues; a negedge monitor pops and compares them.
module tb_sid_filter_ctrl;

    logic        clk;
    logic        rst;
    logic        ce_1m;
    logic        we;
    logic [4:0]  addr;
    logic [7:0]  din;
    logic [10:0] f0_addr;
    logic [17:0] f0_data;
    logic [17:0] eng_f0;
    logic [7:0]  eng_res_filt;
    logic [7:0]  eng_mode_vol;
    logic        eng_valid;
    logic [17:0] eng_sound;
    logic [17:0] sound_out;
    logic        sound_valid;
    logic        busy;
    logic        overrun;
    logic [7:0]  overrun_cnt;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int ovr_n  = 0;

    logic [33:0] exp_eng_q[$];
    logic [17:0] exp_snd_q[$];
    logic [7:0]  exp_ovr_q[$];
    logic [33:0] m_eng;
    logic [17:0] m_snd;
    logic [7:0]  m_ovr;

    sid_filter_ctrl #(.ENG_CYCLES(11)) dut (
        .clk(clk), .rst(rst), .ce_1m(ce_1m), .we(we), .addr(addr), .din(din),
        .f0_addr(f0_addr), .f0_data(f0_data),
        .eng_f0(eng_f0), .eng_res_filt(eng_res_filt), .eng_mode_vol(eng_mode_vol),
        .eng_valid(eng_valid), .eng_sound(eng_sound),
        .sound_out(sound_out), .sound_valid(sound_valid),
        .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] rom(input logic [10:0] a);
        return {a[3:0], 3'b000, a} ^ 18'h15A5A;
    endfunction

    // cutoff ROM with one cycle of read latency
    always_ff @(posedge clk) f0_data <= rom(f0_addr);

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_valid) begin
                if (exp_eng_q.size() == 0) begin
                    chk("eng_valid_unexpected", 34'd1, 34'd0);
                end else begin
                    m_eng = exp_eng_q.pop_front();
                    chk("eng_coeffs", {eng_f0, eng_res_filt, eng_mode_vol}, m_eng);
                end
            end
            if (sound_valid) begin
                if (exp_snd_q.size() == 0) begin
                    chk("sound_valid_unexpected", 34'd1, 34'd0);
                end else begin
                    m_snd = exp_snd_q.pop_front();
                    chk("sound_out", {16'd0, sound_out}, {16'd0, m_snd});
                end
            end
            if (overrun) begin
                if (exp_ovr_q.size() == 0) begin
                    chk("overrun_unexpected", 34'd1, 34'd0);
                end else begin
                    m_ovr = exp_ovr_q.pop_front();
                    chk("overrun_cnt", {26'd0, overrun_cnt}, {26'd0, m_ovr});
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; din = d;
        step();
        we = 1'b0;
    endtask

    task automatic push_ovr();
`ifdef SID_FILTER_OVERRUN_CNT_EN
        exp_ovr_q.push_back(ovr_n > 255 ? 8'hFF : 8'(ovr_n));
`else
        exp_ovr_q.push_back(8'd0);
`endif
        ovr_n++;
    endtask

    // mode: 0 plain, 1 write in LOAD, 2 write with the tick, 3 overrun at T+6,
    //       4 tick held through the whole run, 5 reset at T+5
    task automatic run(input logic [17:0] snd, input bit exp_snd, input logic [10:0] ea,
                       input logic [7:0] er, input logic [7:0] em, input int mode,
                       input logic [4:0] wa, input logic [7:0] wd);
        exp_eng_q.push_back({rom(ea), er, em});
        if (exp_snd) exp_snd_q.push_back(snd);
        ce_1m = 1'b1;
        if (mode == 2) begin we = 1'b1; addr = wa; din = wd; end
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) begin
                ce_1m = (mode == 4);
                we = 1'b0;
                chk("busy_t1", {33'd0, busy}, 34'd1);
                chk("f0_addr_t1", {23'd0, f0_addr}, {23'd0, ea});
            end
            if (k == 2 && mode == 1) begin we = 1'b1; addr = wa; din = wd; end
            if (k == 3) we = 1'b0;
            if (k == 4) eng_sound = snd;
            if (k == 5) begin
                eng_sound = 18'h3C3C3;
                if (mode == 5) rst = 1'b1;
            end
            if (k == 6 && mode == 5) begin
                rst = 1'b0;
                chk("busy_after_abort", {33'd0, busy}, 34'd0);
                chk("state_after_abort", {31'd0, dbg_state}, 34'd0);
                break;
            end
            if (k == 6 && mode == 3) begin ce_1m = 1'b1; push_ovr(); end
            if (k == 7 && mode == 3) ce_1m = 1'b0;
            if (mode == 4 && k <= 13) push_ovr();
            if (k == 13) chk("busy_t13", {33'd0, busy}, 34'd1);
            if (k == 14) begin
                ce_1m = 1'b0;
                chk("busy_t14", {33'd0, busy}, 34'd0);
            end
        end
        step();
    endtask

    initial begin
        rst = 1'b1; ce_1m = 1'b0; we = 1'b0; addr = '0; din = '0; eng_sound = '0;
        repeat (3) step();
        chk("rst_busy", {33'd0, busy}, 34'd0);
        chk("rst_state", {31'd0, dbg_state}, 34'd0);
        chk("rst_eng", {eng_f0, eng_res_filt, eng_mode_vol}, 34'd0);
        chk("rst_eng_valid", {33'd0, eng_valid}, 34'd0);
        chk("rst_sound", {15'd0, sound_out, sound_valid}, 34'd0);
        chk("rst_overrun", {25'd0, overrun_cnt, overrun}, 34'd0);
        chk("rst_f0_addr", {23'd0, f0_addr}, 34'd0);
        rst = 1'b0;
        step();

        wr(5'h16, 8'h80);
        wr(5'h15, 8'h05);
        wr(5'h17, 8'hF1);
        wr(5'h18, 8'h1F);
        wr(5'h10, 8'hFF);
        chk("f0_addr_shadow", {23'd0, f0_addr}, {23'd0, 11'h405});

        // first run after reset: capture happens but is not qualified
        run(18'h11111, 1'b0, 11'h405, 8'hF1, 8'h1F, 0, 5'h0, 8'h0);
        chk("sound_hold", {16'd0, sound_out}, {16'd0, 18'h11111});
        run(18'h1234A, 1'b1, 11'h405, 8'hF1, 8'h1F, 0, 5'h0, 8'h0);
        run(18'h00ABC, 1'b1, 11'h405, 8'hF1, 8'h1F, 1, 5'h18, 8'h0F);
        chk("load_write_held", {26'd0, eng_mode_vol}, {26'd0, 8'h1F});
        run(18'h3FFFF, 1'b1, 11'h405, 8'hF1, 8'h0F, 0, 5'h0, 8'h0);
        run(18'h20001, 1'b1, 11'h095, 8'hF1, 8'h0F, 2, 5'h16, 8'h12);
        run(18'h0F0F0, 1'b1, 11'h095, 8'hF1, 8'h0F, 3, 5'h0, 8'h0);
        for (int i = 0; i < 25; i++) begin
            run(18'(i * 18'h0101 + 18'h00777), 1'b1, 11'h095, 8'hF1, 8'h0F, 4, 5'h0, 8'h0);
        end
`ifdef SID_FILTER_OVERRUN_CNT_EN
        chk("overrun_cnt_sat", {26'd0, overrun_cnt}, {26'd0, 8'hFF});
`else
        chk("overrun_cnt_tied", {26'd0, overrun_cnt}, 34'd0);
`endif

        // reset mid-run: no qualifier for the aborted sample, shadows cleared
        run(18'h15555, 1'b0, 11'h095, 8'hF1, 8'h0F, 5, 5'h0, 8'h0);
        chk("abort_sound_out", {16'd0, sound_out}, 34'd0);
        chk("abort_eng_f0", {16'd0, eng_f0}, 34'd0);
        chk("abort_f0_addr", {23'd0, f0_addr}, 34'd0);
        chk("abort_overrun_cnt", {26'd0, overrun_cnt}, 34'd0);
        run(18'h2AAAA, 1'b0, 11'h000, 8'h00, 8'h00, 0, 5'h0, 8'h0);
        run(18'h01234, 1'b1, 11'h000, 8'h00, 8'h00, 0, 5'h0, 8'h0);

        repeat (3) step();
        chk("eng_q_drained", 34'(exp_eng_q.size()), 34'd0);
        chk("snd_q_drained", 34'(exp_snd_q.size()), 34'd0);
        chk("ovr_q_drained", 34'(exp_ovr_q.size()), 34'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
